branch_predictor: RTL

- Fetch-side counterpart of the execute-stage branch resolver: predicts branch/jump outcomes at fetch and checks them against the resolved `Diverge` outcome at execute.
- Holds a direct-mapped table of 2-bit saturating counters, redirects fetch on predicted-taken B-type branches and JAL, and flags mispredicts with the corrected PC.
- Keeps saturating performance counters for branches resolved and mispredicts.
- Sits between the PC/IMEM fetch logic and the execute stage.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counters, fetch redirect for
// taken B-type branches and JAL, execute-stage mispredict check and statistics.
module branch_predictor #(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_valid,
   input  logic [31:0] f_pc,
   input  logic [31:0] f_instr,
   output logic        f_redirect,
   output logic [31:0] f_target,
   input  logic        e_valid,
   input  logic [31:0] e_pc,
   input  logic [6:0]  e_opcode,
   input  logic        e_diverge,
   input  logic        e_pred_taken,
   input  logic [31:0] e_target,
   output logic        e_mispredict,
   output logic [31:0] e_correct_pc,
   input  logic        stat_clear,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int unsigned CNT_W = 2;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [CNT_W-1:0] CNT_RESET = 2'b01;
   localparam logic [CNT_W-1:0] CNT_MAX   = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MIN   = 2'b00;

   logic [CNT_W-1:0] cnt [ENTRIES];

   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] e_idx;
   logic [31:0]      b_imm;
   logic [31:0]      j_imm;
   logic             e_is_branch;
   logic             e_update;

   assign f_idx       = f_pc[IDX_W+1:2];
   assign e_idx       = e_pc[IDX_W+1:2];
   assign b_imm       = {{20{f_instr[31]}}, f_instr[7], f_instr[30:25], f_instr[11:8], 1'b0};
   assign j_imm       = {{12{f_instr[31]}}, f_instr[19:12], f_instr[20], f_instr[30:21], 1'b0};
   assign e_is_branch = (e_opcode == OP_BRANCH);
   assign e_update    = e_valid & e_is_branch;

   // Fetch prediction: reads the table before this cycle's update lands.
   always_comb begin
      f_redirect = 1'b0;
      f_target   = f_pc + b_imm;
      unique case (f_instr[6:0])
         OP_BRANCH: f_redirect = f_valid & cnt[f_idx][1];
         OP_JAL: begin
            f_redirect = f_valid;
            f_target   = f_pc + j_imm;
         end
         default: f_redirect = 1'b0;
      endcase
   end

   // Execute check; JAL is always predicted correctly, JALR never predicted.
   always_comb begin
      e_mispredict = 1'b0;
      unique case (e_opcode)
         OP_BRANCH: e_mispredict = e_valid & (e_diverge != e_pred_taken);
         OP_JALR:   e_mispredict = e_valid & e_diverge;
         default:   e_mispredict = 1'b0;
      endcase
      e_correct_pc = e_diverge ? e_target : e_pc + 32'd4;
   end

   // Saturating counter update from resolved B-type branches only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt[i] <= CNT_RESET;
         end
      end else if (e_update) begin
         if (e_diverge) begin
            if (cnt[e_idx] != CNT_MAX) begin
               cnt[e_idx] <= CNT_W'(cnt[e_idx] + 2'd1);
            end
         end else begin
            if (cnt[e_idx] != CNT_MIN) begin
               cnt[e_idx] <= CNT_W'(cnt[e_idx] - 2'd1);
            end
         end
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else if (stat_clear) begin
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else begin
         if (e_update && (stat_branches != 32'hFFFF_FFFF)) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (e_mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end

endmodule
